// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: pipelined carry-select adder, one BLK-bit block resolved per stage.
// Define PIPELINED_CSEL_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPELINED_CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NBLK = WIDTH / BLK;
  logic [NBLK-1:0] v_q, c_q, ci;
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] s_q [NBLK];
  logic [BLK-1:0] xa [NBLK];
  logic [BLK-1:0] xb [NBLK];
  logic [BLK:0] res [NBLK];
  // Returns {carry_out, block_sum}; the sum picks the candidate matching the real carry-in.
  function automatic logic [BLK:0] csel(input logic [BLK-1:0] x, input logic [BLK-1:0] y, input logic cin);
    logic [BLK:0] r0, r1;
    logic sel;
    r0 = {1'b0, x} + {1'b0, y};
    r1 = {1'b0, x} + {1'b0, y} + (BLK+1)'(1);
    sel = r0[BLK] | (cin & r1[BLK]);
    return {sel, cin ? r1[BLK-1:0] : r0[BLK-1:0]};
  endfunction
  always_comb begin
    xa[0] = a[BLK-1:0];
    xb[0] = b[BLK-1:0];
    ci[0] = c_in;
    for (int k = 1; k < NBLK; k++) begin
      xa[k] = a_q[k-1][k*BLK +: BLK];
      xb[k] = b_q[k-1][k*BLK +: BLK];
      ci[k] = c_q[k-1];
    end
    for (int k = 0; k < NBLK; k++) res[k] = csel(xa[k], xb[k], ci[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (in_ready) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b;
      s_q[0] <= WIDTH'(res[0][BLK-1:0]);
      for (int k = 1; k < NBLK; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_q[k-1] | (WIDTH'(res[k][BLK-1:0]) << (k*BLK));
      end
      for (int k = 0; k < NBLK; k++) c_q[k] <= res[k][BLK];
    end
  end
`ifdef PIPELINED_CSEL_OVF_EN
  // Carry into the MSB is recovered as x ^ y ^ s at the top bit of the last block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (in_ready) ovf <= xa[NBLK-1][BLK-1] ^ xb[NBLK-1][BLK-1] ^ res[NBLK-1][BLK-1] ^ res[NBLK-1][BLK];
  end
`endif
  assign out_valid = v_q[NBLK-1];
  assign in_ready = !out_valid | out_ready;
  assign sum = s_q[NBLK-1];
  assign c_out = c_q[NBLK-1];
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: three adders (BLK 1/4/16) on shared stimulus, scoreboarded against plain a+b+c_in.
module tb_pipelined_csel_adder;
`ifdef PIPELINED_CSEL_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  localparam logic [17:0] OV = OVF ? 18'h20000 : 18'h0;
  localparam int NB [3] = '{16, 4, 1};
  typedef struct {
    logic [17:0] r;
    int cyc;
    int stl;
  } ent_t;
  logic clk = 1'b0, rst_n, in_valid, c_in, out_ready;
  logic [15:0] a, b;
  logic [2:0] ov, ir, co, of;
  logic [2:0][15:0] sw;
  int checks = 0, errors = 0, cyc = 0;
  int acc [3] = '{0, 0, 0};
  int stl [3] = '{0, 0, 0};
  int acc0 [3];
  bit held [3] = '{0, 0, 0};
  logic [17:0] hv [3];
  ent_t q [3][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipelined_csel_adder #(.WIDTH(16), .BLK(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .c_in(c_in), .out_valid(ov[0]), .out_ready(out_ready), .sum(sw[0]), .c_out(co[0])
`ifdef PIPELINED_CSEL_OVF_EN
    , .ovf(of[0])
`endif
  );
  pipelined_csel_adder #(.WIDTH(16), .BLK(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .c_in(c_in), .out_valid(ov[1]), .out_ready(out_ready), .sum(sw[1]), .c_out(co[1])
`ifdef PIPELINED_CSEL_OVF_EN
    , .ovf(of[1])
`endif
  );
  pipelined_csel_adder #(.WIDTH(16), .BLK(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .c_in(c_in), .out_valid(ov[2]), .out_ready(out_ready), .sum(sw[2]), .c_out(co[2])
`ifdef PIPELINED_CSEL_OVF_EN
    , .ovf(of[2])
`endif
  );
`ifndef PIPELINED_CSEL_OVF_EN
  assign of = '0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic o;
    t = 17'(x) + 17'(y) + 17'(c);
    o = (x[15] == y[15]) && (t[15] != x[15]);
    return {OVF & o, t};
  endfunction
  function automatic logic [17:0] res(input int d);
    return {of[d], co[d], sw[d]};
  endfunction
  function automatic logic [15:0] rnd();
    int s;
    s = $urandom_range(0, 7);
    return s == 0 ? 16'hFFFF : s == 1 ? 16'h0000 : s == 2 ? 16'h8000 : 16'($urandom);
  endfunction
  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic c);
    in_valid = v;
    a = x;
    b = y;
    c_in = c;
  endtask
  // Sampled mid-cycle: what is seen here is exactly what the next rising edge acts on.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q[d].delete();
        held[d] = 0;
      end else begin
        if (held[d]) begin
          check($sformatf("hold_v%0d", d), ov[d], 1);
          check($sformatf("hold_r%0d", d), res(d), hv[d]);
        end
        if (ov[d] && out_ready) begin
          if (q[d].size() == 0) check($sformatf("extra%0d", d), 1, 0);
          else begin
            ent_t e;
            e = q[d].pop_front();
            check($sformatf("sum%0d", d), res(d), e.r);
            check($sformatf("lat%0d", d), cyc - e.cyc, NB[d] + stl[d] - e.stl);
          end
        end
        held[d] = ov[d] && !out_ready;
        hv[d] = res(d);
        if (!ir[d]) stl[d]++;
        if (in_valid && ir[d]) begin
          q[d].push_back('{model(a, b, c_in), cyc, stl[d]});
          acc[d]++;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic bc [4];
    bit done;
    rst_n = 0;
    out_ready = 1;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_v", ov, 0);
    check("rst_s", sw[1], 0);
    check("rst_c", co[1], 0);
    check("rst_rdy", ir, 3'b111);
    @(posedge clk); #1 rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      check("idle", ov, 0);
    end
    @(posedge clk); #1 drive(1, 16'hFFFF, 16'h0000, 1);
    @(posedge clk); #1 in_valid = 0;
    repeat (3) begin
      @(negedge clk);
      check("ripple_early", ov[1], 0);
    end
    @(negedge clk);
    check("ripple_v", ov[1], 1);
    check("ripple", res(1), 18'h10000);
    @(posedge clk); #1 drive(1, 16'h1234, 16'h4321, 0);
    @(posedge clk); #1 drive(1, 16'h8000, 16'h8000, 0);
    @(posedge clk); #1 drive(1, 16'h00FF, 16'h0001, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    check("b2b_early", ov[1], 0);
    @(negedge clk);
    check("b2b0", {ov[1], res(1)}, {1'b1, 18'h05555});
    @(negedge clk);
    check("b2b1", {ov[1], res(1)}, {1'b1, 18'h10000 | OV});
    @(negedge clk);
    check("b2b2", {ov[1], res(1)}, {1'b1, 18'h00101});
    @(negedge clk);
    check("b2b_end", ov[1], 0);
    for (int k = 0; k < 4; k++) begin
      ba[k] = rnd();
      bb[k] = rnd();
      bc[k] = 1'($urandom);
      @(posedge clk); #1 drive(1, ba[k], bb[k], bc[k]);
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 0;
    repeat (5) begin
      @(negedge clk);
      check("bp_v", ov[1], 1);
      check("bp_rdy", ir[1], 0);
      check("bp_hold", res(1), model(ba[0], bb[0], bc[0]));
    end
    @(posedge clk); #1 out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_drain", {ov[1], res(1)}, {1'b1, model(ba[k], bb[k], bc[k])});
    end
    @(negedge clk);
    check("bp_end", ov[1], 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 drive(1, rnd(), rnd(), 1'($urandom));
    end
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 check("pre_rst_v", ov[1], 1);
    #1 rst_n = 0;
    #1 check("rst_async_v", ov, 0);
    check("rst_async_s", sw[1], 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 drive(1, 16'h0001, 16'h0001, 0);
    @(posedge clk); #1 in_valid = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_early", ov[1], 0);
    end
    @(negedge clk);
    check("post_rst", {ov[1], res(1)}, {1'b1, 18'h00002});
    acc0 = acc;
    done = 0;
    for (int n = 0; n < 6000 && !done; n++) begin
      @(posedge clk); #1 drive($urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom));
      out_ready = $urandom_range(0, 4) != 0;
      done = 1;
      for (int d = 0; d < 3; d++) if (acc[d] - acc0[d] < 1000) done = 0;
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    for (int n = 0; n < 60 && (q[0].size() + q[1].size() + q[2].size()) != 0; n++) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("accepts%0d", d), acc[d] - acc0[d] >= 1000, 1);
      check($sformatf("drained%0d", d), q[d].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
